// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and defaults for the divided-clock monitor
package clk_div_pkg;

  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_e;

endpackage

// File: rtl/edge_sync_detect.sv
// rtl/edge_sync_detect.sv - synchroniser plus history flop producing rise/fall strobes
module edge_sync_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic s;
  logic s_d_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = i_d;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= i_d;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s_d_q <= 1'b0;
    end else begin
      s_d_q <= s;
    end
  end

  assign o_rise = s & ~s_d_q;
  assign o_fall = ~s & s_d_q;

endmodule

// File: rtl/clk_div_ratio_detector.sv
// rtl/clk_div_ratio_detector.sv - measures period/high time of a divided clock and reports lock
module clk_div_ratio_detector
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 1000
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic             i_clk_in,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_even,
  output logic             o_locked,
  output logic             o_timeout
);

  localparam int                 MATCH_W  = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]   TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [MATCH_W-1:0] LOCK_MAX = MATCH_W'(LOCK_CNT);
  localparam logic [MATCH_W-1:0] LOCK_PRE = MATCH_W'(LOCK_CNT - 1);

  logic               rise, fall;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   high_tmp_q, high_tmp_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic               valid_q, valid_d;
  logic               even_q, even_d;
  logic               locked_q, locked_d;
  logic               timeout_q, timeout_d;
  logic [MATCH_W-1:0] match_q, match_d;

  edge_sync_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_d    (i_clk_in),
    .o_rise (rise),
    .o_fall (fall)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_tmp_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      even_q     <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
      match_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_tmp_q <= high_tmp_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      even_q     <= even_d;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
      match_q    <= match_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_tmp_d = high_tmp_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    even_d     = even_q;
    locked_d   = locked_q;
    timeout_d  = 1'b0;
    match_d    = match_q;

    if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (!i_en) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      match_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d    = ARMED;
            high_tmp_d = '0;
          end
        end
        ARMED, MEASURE: begin
          if (rise) begin
            state_d    = MEASURE;
            high_tmp_d = '0;
            period_d   = cnt_q;
            high_d     = high_tmp_q;
            even_d     = ~cnt_q[0] && (high_tmp_q == (cnt_q >> 1));
            valid_d    = 1'b1;
            // The publish that closes the ARMED period has no valid predecessor.
            if (state_q == MEASURE && cnt_q == period_q) begin
              if (match_q != LOCK_MAX) match_d = match_q + 1'b1;
              if (match_q >= LOCK_PRE) locked_d = 1'b1;
            end else begin
              match_d  = MATCH_W'(1);
              locked_d = 1'b0;
            end
          end else begin
            if (fall) high_tmp_d = cnt_q;
            if (cnt_q == TO_VAL) begin
              timeout_d = 1'b1;
              locked_d  = 1'b0;
              match_d   = '0;
              state_d   = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_period  = period_q;
  assign o_high    = high_q;
  assign o_valid   = valid_q;
  assign o_even    = even_q;
  assign o_locked  = locked_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_clk_div_ratio_detector.sv
// tb/tb_clk_div_ratio_detector.sv - randomized self-checking bench with behavioural reference model
module tb_clk_div_ratio_detector;

  localparam int LOCK    = 4;
  localparam int TMO     = 1000;
  localparam int K_ZERO  = 0, K_DIV4 = 1, K_DIV3 = 2, K_DIV6A = 3, K_DIV6B = 4,
                 K_MARK  = 5, K_TMO  = 6, K_P1000 = 7, K_P1001 = 8, K_ENDROP = 9;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic i_en = 1'b0;
  logic i_clk_in = 1'b0;

  logic [15:0] per_o [2];
  logic [15:0] high_o [2];
  logic        val_o [2];
  logic        even_o [2];
  logic        lock_o [2];
  logic        to_o [2];

  always #5 clk = ~clk;

  clk_div_ratio_detector #(.CNT_W(16), .SYNC_STAGES(2), .LOCK_CNT(LOCK), .TIMEOUT(TMO)) u_dut2 (
    .i_clk(clk), .i_rstn(rstn), .i_en(i_en), .i_clk_in(i_clk_in),
    .o_period(per_o[0]), .o_high(high_o[0]), .o_valid(val_o[0]),
    .o_even(even_o[0]), .o_locked(lock_o[0]), .o_timeout(to_o[0])
  );

  clk_div_ratio_detector #(.CNT_W(16), .SYNC_STAGES(0), .LOCK_CNT(LOCK), .TIMEOUT(TMO)) u_dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_en(i_en), .i_clk_in(i_clk_in),
    .o_period(per_o[1]), .o_high(high_o[1]), .o_valid(val_o[1]),
    .o_even(even_o[1]), .o_locked(lock_o[1]), .o_timeout(to_o[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: edge timestamps on the input as seen after the synchroniser delay.
  logic [3:0] hist [2];
  int  active [2], first [2], last_rise [2], fall_at [2], run [2];
  int  e_per [2], e_high [2];
  bit  e_val [2], e_even [2], e_lock [2], e_to [2];
  logic [3:0] m_h;
  bit  m_rise, m_fall;
  int  m_p, m_dly;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        hist[k] = '0; active[k] = 0; first[k] = 0; last_rise[k] = 0; fall_at[k] = -1;
        run[k] = 0; e_per[k] = 0; e_high[k] = 0;
        e_val[k] = 0; e_even[k] = 0; e_lock[k] = 0; e_to[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_dly   = (k == 0) ? 2 : 0;
        m_h     = {hist[k][2:0], i_clk_in};
        hist[k] = m_h;
        m_rise  = m_h[m_dly] && !m_h[m_dly+1];
        m_fall  = !m_h[m_dly] && m_h[m_dly+1];
        e_val[k] = 0;
        e_to[k]  = 0;
        if (!i_en) begin
          active[k] = 0; run[k] = 0; e_lock[k] = 0;
        end else if (active[k] == 0) begin
          if (m_rise) begin
            active[k] = 1; first[k] = 1; last_rise[k] = cyc; fall_at[k] = -1;
          end
        end else begin
          m_p = cyc - last_rise[k];
          if (m_rise) begin
            e_val[k]  = 1;
            e_high[k] = (fall_at[k] < 0) ? 0 : fall_at[k] - last_rise[k];
            e_even[k] = (m_p % 2 == 0) && (e_high[k] * 2 == m_p);
            if (first[k] == 0 && m_p == e_per[k]) begin
              if (run[k] < LOCK) run[k]++;
              if (run[k] >= LOCK) e_lock[k] = 1;
            end else begin
              run[k] = 1; e_lock[k] = 0;
            end
            e_per[k] = m_p; first[k] = 0; last_rise[k] = cyc; fall_at[k] = -1;
          end else begin
            if (m_fall) fall_at[k] = cyc;
            if (m_p == TMO) begin
              e_to[k] = 1; active[k] = 0; run[k] = 0; e_lock[k] = 0;
            end
          end
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int last_rise_drv = -100;
  int pin_seq = 0, pin_kind = 0;
  int pin_done = 0;
  int nvalid = 0, lock_at = 0;
  bit lock_prev = 0;
  int nto [2] = '{0, 0};
  int to_mark [2] = '{0, 0};

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0d expected=%0d t=%0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic do_pin(input int kind);
    case (kind)
      K_ZERO: for (int k = 0; k < 2; k++) begin
        chk("zero_period", k, per_o[k], 0); chk("zero_high", k, high_o[k], 0);
        chk("zero_valid", k, val_o[k], 0);  chk("zero_even", k, even_o[k], 0);
        chk("zero_locked", k, lock_o[k], 0); chk("zero_timeout", k, to_o[k], 0);
      end
      K_DIV4: begin
        chk("div4_period", 0, per_o[0], 4); chk("div4_high", 0, high_o[0], 2);
        chk("div4_even", 0, even_o[0], 1);  chk("div4_locked", 0, lock_o[0], 1);
        chk("div4_lock_on_valid", 0, lock_at, 4);
      end
      K_DIV3: begin
        chk("div3_period", 0, per_o[0], 3); chk("div3_high", 0, high_o[0], 1);
        chk("div3_even", 0, even_o[0], 0);  chk("div3_locked", 0, lock_o[0], 1);
      end
      K_DIV6A: begin
        chk("div6_period", 0, per_o[0], 6); chk("div6_high", 0, high_o[0], 3);
        chk("div6_unlocked", 0, lock_o[0], 0);
      end
      K_DIV6B: begin
        chk("div6_relock", 0, lock_o[0], 1); chk("div6_even", 0, even_o[0], 1);
      end
      K_MARK: for (int k = 0; k < 2; k++) to_mark[k] = nto[k];
      K_TMO: for (int k = 0; k < 2; k++) begin
        chk("timeout_pulses", k, nto[k] - to_mark[k], 1);
        chk("timeout_unlocked", k, lock_o[k], 0);
        chk("timeout_period_held", k, per_o[k], 4);
      end
      K_P1000: for (int k = 0; k < 2; k++) begin
        chk("p1000_period", k, per_o[k], 1000); chk("p1000_high", k, high_o[k], 1);
        chk("p1000_no_timeout", k, nto[k] - to_mark[k], 0);
      end
      K_P1001: for (int k = 0; k < 2; k++) chk("p1001_timeout", k, nto[k] - to_mark[k], 1);
      K_ENDROP: for (int k = 0; k < 2; k++) begin
        chk("endrop_unlocked", k, lock_o[k], 0);
        chk("endrop_period_held", k, per_o[k], 4);
        chk("endrop_high_held", k, high_o[k], 2);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("period", k, per_o[k], e_per[k]);
      chk("high", k, high_o[k], e_high[k]);
      chk("valid", k, val_o[k], e_val[k]);
      chk("even", k, even_o[k], e_even[k]);
      chk("locked", k, lock_o[k], e_lock[k]);
      chk("timeout", k, to_o[k], e_to[k]);
      if (to_o[k]) nto[k]++;
      if (rstn && val_o[k]) chk("latency", k, cyc - last_rise_drv, (k == 0) ? 3 : 1);
    end
    if (!rstn || !i_en) nvalid = 0;
    else if (val_o[0]) nvalid++;
    if (lock_o[0] && !lock_prev) lock_at = nvalid;
    lock_prev = lock_o[0];
    if (pin_seq != pin_done) begin
      do_pin(pin_kind);
      pin_done = pin_seq;
    end
  end

  task automatic step(input bit v);
    @(negedge clk);
    #1;
    if (v && !i_clk_in) last_rise_drv = cyc;
    i_clk_in = v;
  endtask

  task automatic drive(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
    end
  endtask

  task automatic pin(input int kind);
    pin_kind = kind;
    pin_seq++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1 rstn = 1'b0;
    repeat (3) step(1'b0);
    pin(K_ZERO);
    rstn = 1'b1;
    step(1'b0);
    i_en = 1'b1;
    drive(2, 2, 8);  pin(K_DIV4);
    drive(1, 2, 8);  pin(K_DIV3);
    drive(2, 2, 8);
    drive(3, 3, 2);  pin(K_DIV6A);
    drive(3, 3, 6);  pin(K_DIV6B);
    drive(2, 2, 8);  pin(K_MARK);
    repeat (1010) step(1'b0);
    pin(K_TMO);
    drive(2, 2, 5);  pin(K_MARK);
    drive(1, 999, 1);
    repeat (4) step(1'b1);
    pin(K_P1000);
    drive(1, 1000, 1);
    pin(K_P1001);
    drive(2, 2, 3);
    step(1'b1);
    #2 rstn = 1'b0;
    #20 rstn = 1'b1;
    pin(K_ZERO);
    drive(2, 2, 6);
    step(1'b1);
    i_en = 1'b0;
    drive(2, 2, 2);
    pin(K_ENDROP);
    step(1'b1);
    i_en = 1'b1;
    drive(2, 2, 6);
    for (int s = 0; s < 40; s++) begin
      int hi, lo, n;
      hi = $urandom_range(1, 4);
      lo = $urandom_range(2, 4);
      n  = $urandom_range(1, 6);
      if ($urandom_range(0, 7) == 0) begin
        i_en = 1'b0;
        drive(hi, lo, 1);
        i_en = 1'b1;
      end
      drive(hi, lo, n);
    end
    repeat (5) step(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
